nn_scale_stream: RTL and testbench

Streaming nearest-neighbour image scaler. It accepts one raster-order frame of pixels over a valid/ready input stream and emits the rescaled frame over a valid/ready output stream. Input and output sizes and the horizontal/vertical step factors are set per frame at run time, so the block supports independent up- and down-scaling on each axis. It sits between the pixel source (file reader or upstream filter) and the pixel sink in the image pipeline, and buffers one source row on chip.

---
 rtl/img_pkg.sv | 24 ++
 rtl/nn_line_buf.sv | 28 ++
 rtl/nn_scale_stream.sv | 224 ++++++++++++++++++++++
 tb/tb_nn_scale_stream.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared constants, FSM state type and index helper for the image pipeline blocks.
package img_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int MAX_COLS_DEF = 1024;
  localparam int MAX_ROWS_DEF = 1024;
  localparam int FRAC_W_DEF   = 8;
  localparam int IDX_W_DEF    =
    $clog2(((MAX_COLS_DEF > MAX_ROWS_DEF) ? MAX_COLS_DEF : MAX_ROWS_DEF) + 1);
  localparam int STEP_W_DEF   = IDX_W_DEF + FRAC_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } nn_state_t;

  // Saturate a source index to the last valid row/column.
  function automatic int clamp_idx(input int idx, input int lim);
    return (idx > lim) ? lim : idx;
  endfunction

endpackage

// File: rtl/nn_line_buf.sv
// One-row line buffer: simple dual-port RAM, synchronous write, 1-cycle read.
module nn_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store incoming pixel
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered output, held when not enabled
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nn_scale_stream.sv
// Streaming nearest-neighbour scaler: buffers one source row, re-reads it for
// every output row that maps onto it, and streams the result through a skid FIFO.
module nn_scale_stream
  import img_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_COLS = MAX_COLS_DEF,
  parameter int MAX_ROWS = MAX_ROWS_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  localparam int IDX_W   = $clog2(((MAX_COLS > MAX_ROWS) ? MAX_COLS : MAX_ROWS) + 1),
  localparam int STEP_W  = IDX_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  in_rows,
  input  logic [IDX_W-1:0]  in_cols,
  input  logic [IDX_W-1:0]  out_rows,
  input  logic [IDX_W-1:0]  out_cols,
  input  logic [STEP_W-1:0] step_v,
  input  logic [STEP_W-1:0] step_h,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = STEP_W + 1;
  localparam int AW    = $clog2(MAX_COLS);

  nn_state_t         state, state_nxt;
  logic [IDX_W-1:0]  in_rows_q, in_cols_q, out_rows_q, out_cols_q;
  logic [STEP_W-1:0] step_v_q, step_h_q;
  logic [ACC_W-1:0]  acc_v, acc_h, acc_v_sum;
  logic [IDX_W-1:0]  col_cnt, rows_in, tgt_row, tgt_nxt, ox, oy;
  logic [AW-1:0]     src_col;
  int                src_i, tgt_i;
  logic              start_ok, cfg_zero, s_fire, row_fire;
  logic              in_done_cur, in_done_nxt, out_empty_nxt;
  logic              ox_last, oy_last, issue, fin, pop;
  logic [2:0]        occ;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld_p1, rd_eol_p1, rd_eof_p1;
  logic [DATA_W-1:0] f_data [2];
  logic [1:0]        f_eol, f_eof;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;

  assign start_ok   = start && (state == IDLE) && !busy && !done;
  assign cfg_zero   = (in_rows == '0) || (in_cols == '0) ||
                      (out_rows == '0) || (out_cols == '0);
  assign s_ready    = (state == LOAD) || ((state == DRAIN) && !in_done_cur);
  assign s_fire     = s_valid && s_ready;
  assign row_fire   = s_fire && (col_cnt == in_cols_q - IDX_W'(1));
  assign in_done_cur = (rows_in == in_rows_q);
  assign in_done_nxt = in_done_cur || (row_fire && (rows_in + IDX_W'(1) == in_rows_q));
  assign pop        = m_valid && m_ready;
  assign out_empty_nxt = !rd_vld_p1 && (fifo_cnt == {1'b0, pop});
  assign ox_last    = (ox == out_cols_q - IDX_W'(1));
  assign oy_last    = (oy == out_rows_q - IDX_W'(1));
  assign acc_v_sum  = acc_v + ACC_W'(step_v_q);
  assign tgt_i      = clamp_idx(int'(acc_v_sum >> FRAC_W), int'(in_rows_q) - 1);
  assign tgt_nxt    = IDX_W'(tgt_i);
  assign src_i      = clamp_idx(int'(acc_h >> FRAC_W), int'(in_cols_q) - 1);
  assign src_col    = AW'(src_i);
  // Entries that will occupy the FIFO once this cycle's pop is taken; a new
  // read may only be issued if its data is guaranteed a slot on arrival.
  assign occ        = {1'b0, fifo_cnt} + {2'b0, rd_vld_p1} - {2'b0, pop};

  // Next-state logic: row loading, row emission, tail draining
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok && !cfg_zero) state_nxt = LOAD;
      end
      LOAD: begin
        if (row_fire && (rows_in == tgt_row)) state_nxt = EMIT;
      end
      EMIT: begin
        issue = (occ < 3'd2);
        if (issue && ox_last) begin
          if (oy_last)                             state_nxt = DRAIN;
          else if (tgt_nxt == rows_in - IDX_W'(1)) state_nxt = EMIT;
          else                                     state_nxt = LOAD;
        end
      end
      DRAIN: begin
        fin = in_done_nxt && out_empty_nxt;
        if (fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame status: busy spans start..done; zero-size frames finish one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin || ((state == IDLE) && busy);
      if (start_ok)                            busy <= 1'b1;
      else if (fin || ((state == IDLE) && busy)) busy <= 1'b0;
    end
  end

  // Frame configuration latch
  always_ff @(posedge clk) begin
    if (start_ok) begin
      in_rows_q  <= in_rows;
      in_cols_q  <= in_cols;
      out_rows_q <= out_rows;
      out_cols_q <= out_cols;
      step_v_q   <= step_v;
      step_h_q   <= step_h;
    end
  end

  // Input side: column position within the row and completed row count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      rows_in <= '0;
    end else if (start_ok) begin
      col_cnt <= '0;
      rows_in <= '0;
    end else if (s_fire) begin
      if (row_fire) begin
        col_cnt <= '0;
        rows_in <= rows_in + IDX_W'(1);
      end else begin
        col_cnt <= col_cnt + IDX_W'(1);
      end
    end
  end

  // Output side: position accumulators and the source row currently wanted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_v <= '0; acc_h <= '0; ox <= '0; oy <= '0; tgt_row <= '0;
    end else if (start_ok) begin
      acc_v <= '0; acc_h <= '0; ox <= '0; oy <= '0; tgt_row <= '0;
    end else if (issue) begin
      if (ox_last) begin
        ox      <= '0;
        acc_h   <= '0;
        oy      <= oy + IDX_W'(1);
        acc_v   <= acc_v_sum;
        tgt_row <= tgt_nxt;
      end else begin
        ox      <= ox + IDX_W'(1);
        acc_h   <= acc_h + ACC_W'(step_h_q);
      end
    end
  end

  nn_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_COLS)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (s_fire && (state == LOAD)),
    .wr_addr (AW'(col_cnt)),
    .wr_data (s_data),
    .rd_en   (issue),
    .rd_addr (src_col),
    .rd_data (rd_data)
  );

  // Stage p1: line-buffer read data valid, row/frame markers travel alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
      rd_eol_p1 <= 1'b0;
      rd_eof_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= issue;
      rd_eol_p1 <= issue && ox_last;
      rd_eof_p1 <= issue && ox_last && oy_last;
    end
  end

  // Two-entry skid FIFO decoupling the read pipeline from m_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) f_data[i] <= '0;
      f_eol    <= '0;
      f_eof    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (rd_vld_p1) begin
        f_data[wr_ptr] <= rd_data;
        f_eol[wr_ptr]  <= rd_eol_p1;
        f_eof[wr_ptr]  <= rd_eof_p1;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = f_data[rd_ptr];
  assign m_eol   = m_valid && f_eol[rd_ptr];
  assign m_eof   = m_valid && f_eof[rd_ptr];

endmodule

// File: tb/tb_nn_scale_stream.sv
// Self-checking bench for nn_scale_stream: literal vectors, a table of
// randomized frames against a coordinate-mapping reference model, plus reset
// and zero-size corner sequences.
module tb_nn_scale_stream;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 8;
  localparam int IDX_W  = $clog2(1024 + 1);
  localparam int STEP_W = IDX_W + FRAC_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [IDX_W-1:0]  in_rows, in_cols, out_rows, out_cols;
  logic [STEP_W-1:0] step_v, step_h;
  logic              s_valid, s_ready, m_valid, m_ready;
  logic [DATA_W-1:0] s_data, m_data;
  logic              m_eol, m_eof, busy, done;

  nn_scale_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_rows(in_rows), .in_cols(in_cols), .out_rows(out_rows), .out_cols(out_cols),
    .step_v(step_v), .step_h(step_h),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ir, ic, orr, oc, sv, sh;
  int src_pct = 100, snk_pct = 100;
  int consumed = 0, done_cnt = 0;
  int last_in_cyc = 0, last_out_cyc = 0, done_cyc = 0;
  int unsigned src_px[$];
  int unsigned in_q[$];
  int unsigned exp_q[$];
  logic [9:0]  out_q[$];

  typedef struct {
    int ir, ic, orr, oc, sp, rp, exp_n;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Source: offers queued pixels with random gaps
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      if (in_q.size() > 0 && $urandom_range(99) < src_pct) begin
        s_valid = 1'b1;
        s_data  = DATA_W'(in_q[0]);
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready) begin
        void'(in_q.pop_front());
        consumed++;
        last_in_cyc = cyc;
      end
    end
  end

  // Sink: random backpressure, records handshakes, checks stall stability
  initial begin
    logic       stall_prev;
    logic [9:0] prev;
    stall_prev = 1'b0;
    prev = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        m_ready = 1'b0;
      end else begin
        if (stall_prev)
          check("stall_hold", 64'({m_valid, m_eof, m_eol, m_data}), 64'({1'b1, prev}));
        m_ready = ($urandom_range(99) < snk_pct);
        if (m_valid && m_ready) begin
          out_q.push_back({m_eof, m_eol, m_data});
          last_out_cyc = cyc;
        end
        stall_prev = m_valid && !m_ready;
        prev = {m_eof, m_eol, m_data};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic apply_cfg();
    in_rows  = IDX_W'(ir);
    in_cols  = IDX_W'(ic);
    out_rows = IDX_W'(orr);
    out_cols = IDX_W'(oc);
    step_v   = STEP_W'(sv);
    step_h   = STEP_W'(sh);
  endtask

  task automatic fill_random();
    src_px.delete();
    for (int i = 0; i < ir * ic; i++) src_px.push_back($urandom_range(255));
  endtask

  task automatic run_frame(input string tag);
    int  d0;
    int  lastc;
    bit  got;
    out_q.delete();
    in_q     = src_px;
    consumed = 0;
    d0       = done_cnt;
    apply_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'(1));
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (done_cnt != d0) got = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'(1));
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    check({tag, "_busy_fall"}, 64'(busy), 64'(0));
    check({tag, "_consumed"}, 64'(consumed), 64'(ir * ic));
    lastc = (last_in_cyc > last_out_cyc) ? last_in_cyc : last_out_cyc;
    if (got) check({tag, "_done_timing"}, 64'(done_cyc), 64'(lastc + 1));
  endtask

  // Reference: each output coordinate maps to floor(o*step/2^FRAC_W), clamped
  task automatic cmp_model(input string tag);
    int n;
    n = 0;
    check({tag, "_count"}, 64'(out_q.size()), 64'(orr * oc));
    for (int y = 0; y < orr; y++) begin
      for (int x = 0; x < oc; x++) begin
        int sy, sx;
        logic eol, eof;
        logic [9:0] e;
        sy = (y * sv) >> FRAC_W;
        if (sy > ir - 1) sy = ir - 1;
        sx = (x * sh) >> FRAC_W;
        if (sx > ic - 1) sx = ic - 1;
        eol = (x == oc - 1);
        eof = eol && (y == orr - 1);
        e = {eof, eol, 8'(src_px[sy * ic + sx])};
        if (n < out_q.size())
          check($sformatf("%s_px%0d", tag, n), 64'(out_q[n]), 64'(e));
        n++;
      end
    end
  endtask

  task automatic cmp_literal(input string tag);
    check({tag, "_lit_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_lit%0d", tag, i), 64'(out_q[i][7:0]), 64'(exp_q[i]));
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0;
    start = 1'b0;
    ir = 1; ic = 1; orr = 1; oc = 1; sv = 256; sh = 256;
    apply_cfg();
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data",  64'(m_data),  64'(0));
    check("rst_m_eol",   64'(m_eol),   64'(0));
    check("rst_m_eof",   64'(m_eof),   64'(0));
    check("rst_busy",    64'(busy),    64'(0));
    check("rst_done",    64'(done),    64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2x3 -> 4x6, half-pixel steps
    ir = 2; ic = 3; orr = 4; oc = 6; sv = 128; sh = 128;
    src_px = {1, 2, 3, 4, 5, 6};
    exp_q  = {1, 1, 2, 2, 3, 3, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 4, 4, 5, 5, 6, 6};
    run_frame("up2x");
    cmp_literal("up2x");
    cmp_model("up2x");

    // 4x4 -> 2x2, last input row is drained
    ir = 4; ic = 4; orr = 2; oc = 2; sv = 512; sh = 512;
    src_px.delete();
    for (int i = 0; i < 16; i++) src_px.push_back(i);
    exp_q = {0, 2, 8, 10};
    run_frame("down2x");
    cmp_literal("down2x");
    cmp_model("down2x");

    // 2x2 -> 3x3, fractional step 170
    ir = 2; ic = 2; orr = 3; oc = 3; sv = 170; sh = 170;
    src_px = {10, 20, 30, 40};
    exp_q  = {10, 10, 20, 10, 10, 20, 30, 30, 40};
    run_frame("up15");
    cmp_literal("up15");
    cmp_model("up15");

    // Randomized frames with random valid/ready
    tbl[0] = '{4, 4, 8, 8, 60, 50, 64};
    tbl[1] = '{3, 5, 7, 2, 100, 100, 14};
    tbl[2] = '{5, 7, 3, 4, 60, 80, 12};
    tbl[3] = '{1, 1, 3, 3, 100, 40, 9};
    tbl[4] = '{6, 3, 6, 3, 50, 50, 18};
    tbl[5] = '{2, 8, 5, 1, 70, 30, 5};
    for (int t = 0; t < 6; t++) begin
      ir = tbl[t].ir; ic = tbl[t].ic; orr = tbl[t].orr; oc = tbl[t].oc;
      sv = (ir * 256) / orr;
      sh = (ic * 256) / oc;
      src_pct = tbl[t].sp;
      snk_pct = tbl[t].rp;
      fill_random();
      run_frame($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_n", t), 64'(out_q.size()), 64'(tbl[t].exp_n));
      cmp_model($sformatf("tbl%0d", t));
    end
    src_pct = 100;
    snk_pct = 100;

    // Reset in the middle of emission, then a clean frame
    ir = 4; ic = 4; orr = 8; oc = 8; sv = 128; sh = 128;
    fill_random();
    out_q.delete();
    in_q = src_px;
    apply_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (out_q.size() >= 5) reached = 1'b1;
    end
    check("mid_rst_reached", 64'(reached), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(s_ready), 64'(0));
    check("mid_rst_m_valid", 64'(m_valid), 64'(0));
    check("mid_rst_m_data",  64'(m_data),  64'(0));
    check("mid_rst_m_eol",   64'(m_eol),   64'(0));
    check("mid_rst_m_eof",   64'(m_eof),   64'(0));
    check("mid_rst_busy",    64'(busy),    64'(0));
    check("mid_rst_done",    64'(done),    64'(0));
    @(negedge clk);
    in_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    src_pct = 80;
    snk_pct = 70;
    fill_random();
    run_frame("post_rst");
    cmp_model("post_rst");
    src_pct = 100;
    snk_pct = 100;

    // Zero output width: done one cycle after busy, no stream activity
    ir = 3; ic = 3; orr = 3; oc = 0; sv = 256; sh = 0;
    in_q.delete();
    apply_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_busy",     64'(busy),    64'(1));
    check("zero_done_lo",  64'(done),    64'(0));
    check("zero_s_ready1", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("zero_done_hi",  64'(done),    64'(1));
    check("zero_busy_lo",  64'(busy),    64'(0));
    check("zero_s_ready2", 64'(s_ready), 64'(0));
    check("zero_m_valid",  64'(m_valid), 64'(0));
    @(negedge clk);
    check("zero_done_once", 64'(done),   64'(0));
    check("zero_m_valid2", 64'(m_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
